// File: rtl/busmatrix_arb_pkg.sv
// Shared AHB encodings and arbiter state type for the bus-matrix output-stage arbiter.
package busmatrix_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ARB_IDLE = 1'b0;
    localparam arb_state_t ARB_OWN  = 1'b1;

    // Undefined-length INCR counts as one beat so it is re-arbitrated every beat.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: lowest requesting index at or above ptr_i, wrapping.
module ahb_rr_picker #(
    parameter int NUM_MST = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_MST-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_MST);

    logic [PTR_W:0] pos;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int off = 0; off < NUM_MST; off++) begin
            pos = {1'b0, ptr_i} + (PTR_W+1)'(off);
            if (pos >= NUM_W) begin
                pos = pos - NUM_W;
            end
            if (!found && req_i[pos[PTR_W-1:0]]) begin
                found                   = 1'b1;
                grant_o[pos[PTR_W-1:0]] = 1'b1;
                idx_o                   = pos[PTR_W-1:0];
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ahblite_busmatrix_arbiter.sv
// Round-robin address/data-phase arbiter for one AHB-Lite bus-matrix output stage.
// Define BUSMATRIX_ARB_LOCK_EN to add HMASTLOCK and keep a locked owner granted.
module ahblite_busmatrix_arbiter
    import busmatrix_arb_pkg::*;
#(
    parameter int NUM_MST = 3,
    parameter int CNT_W   = 5
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MST-1:0]     HSEL_REQ,
    input  logic [2*NUM_MST-1:0]   HTRANS_REQ,
    input  logic [3*NUM_MST-1:0]   HBURST_REQ,
`ifdef BUSMATRIX_ARB_LOCK_EN
    input  logic [NUM_MST-1:0]     HMASTLOCK,
`endif
    input  logic                   HREADYOUT_S,
    output logic [NUM_MST-1:0]     ACTIVE,
    output logic [NUM_MST-1:0]     ADDR_SEL,
    output logic [NUM_MST-1:0]     DATA_SEL,
    output logic                   HSEL_S
);

    localparam int PTR_W = $clog2(NUM_MST);

    arb_state_t         state_q, state_d;
    logic [NUM_MST-1:0] addr_sel_q, addr_sel_d;
    logic [NUM_MST-1:0] data_sel_q, data_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_upd;
    logic [PTR_W-1:0]   ptr_q, ptr_d, ptr_nxt;

    logic [NUM_MST-1:0] req, beat, active;
    logic [1:0]         own_trans;
    logic [2:0]         own_burst;
    logic               own_req, own_beat, own_lock, rearb;
    logic [NUM_MST-1:0] pick_grant;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    always_comb begin
        req       = '0;
        beat      = '0;
        own_trans = HTRANS_IDLE;
        own_burst = HBURST_SINGLE;
        own_lock  = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            req[i]  = HSEL_REQ[i] && (HTRANS_REQ[2*i +: 2] != HTRANS_IDLE);
            beat[i] = req[i] && HTRANS_REQ[2*i+1];
            if (addr_sel_q[i]) begin
                own_trans = HTRANS_REQ[2*i +: 2];
                own_burst = HBURST_REQ[3*i +: 3];
`ifdef BUSMATRIX_ARB_LOCK_EN
                own_lock  = HMASTLOCK[i];
`endif
            end
        end
    end

    assign active   = addr_sel_q & req;
    assign own_req  = |active;
    assign own_beat = |(addr_sel_q & beat);

    // Owner is excluded from the candidates; in ARB_IDLE addr_sel_q is zero so all requests compete.
    ahb_rr_picker #(
        .NUM_MST (NUM_MST),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i   (req & ~addr_sel_q),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign ptr_nxt = (pick_idx == PTR_W'(NUM_MST-1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        cnt_upd = cnt_q;
        if (own_beat && own_trans == HTRANS_NONSEQ) begin
            cnt_upd = CNT_W'(burst_len(own_burst) - 5'd1);
        end else if (own_beat && own_trans == HTRANS_SEQ && cnt_q != '0) begin
            cnt_upd = cnt_q - 1'b1;
        end
        rearb = !own_lock && ((own_beat && cnt_upd == '0) || !own_req);
    end

    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        data_sel_d = data_sel_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        if (HREADYOUT_S) begin
            data_sel_d = active & beat;
            if (state_q == ARB_IDLE) begin
                if (pick_any) begin
                    state_d    = ARB_OWN;
                    addr_sel_d = pick_grant;
                    ptr_d      = ptr_nxt;
                end
            end else begin
                cnt_d = cnt_upd;
                if (rearb) begin
                    // The new winner's count loads on its own first NONSEQ, not here.
                    if (pick_any) begin
                        addr_sel_d = pick_grant;
                        ptr_d      = ptr_nxt;
                        cnt_d      = '0;
                    end else if (!own_req) begin
                        state_d    = ARB_IDLE;
                        addr_sel_d = '0;
                        cnt_d      = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ARB_IDLE;
            addr_sel_q <= '0;
            data_sel_q <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
            data_sel_q <= data_sel_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ACTIVE   = active;
    assign ADDR_SEL = addr_sel_q;
    assign DATA_SEL = data_sel_q;
    assign HSEL_S   = |active;

endmodule
